// File: rtl/tcdm_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tcdm_bank_arbiter
//
// Round-robin arbiter sharing one single-port TCDM SRAM bank between
// NUM_MASTERS requesters. At most one access is issued to the bank per cycle.
// Each granted read is tracked through the SRAM cycle (stage 1) and the
// response pipe stage (stage 2). The returning read-valid is steered back to
// the owning master as a one-hot strobe.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   req_i                per-master request
//   add_i, wen_i,        per-master address, write-enable (active-low:
//   wdata_i, be_i          1 = read), write data and byte enables, master k at slice k
//   gnt_o                one-hot grant, combinational in the request cycle
//   mem_req_o, mem_add_o,
//   mem_wen_o, mem_wdata_o,
//   mem_be_o             bank access muxed from the winning master
//   pipe_rvalid_o        read-valid into the response pipe, one cycle after a granted read
//   pipe_valid_i         valid returned by the response pipe
//   r_valid_o            one-hot read-response strobe per master
//   r_id_o               index of the master owning the current response
//
// Optional feature (macro TCDM_ARB_PERF_CNT_EN):
//   cnt_clr_i            synchronous clear of all conflict counters
//   conflict_cnt_o       one saturating 16-bit counter per master, counting
//                        cycles where the master requested but was not granted
// -----------------------------------------------------------------------------
module tcdm_bank_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = $clog2(NUM_MASTERS)
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic [NUM_MASTERS-1:0]            req_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] add_i,
  input  logic [NUM_MASTERS-1:0]            wen_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   be_i,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              mem_req_o,
  output logic [ADDR_WIDTH-1:0]             mem_add_o,
  output logic                              mem_wen_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  output logic [BE_WIDTH-1:0]               mem_be_o,
  output logic                              pipe_rvalid_o,
  input  logic                              pipe_valid_i,
  output logic [NUM_MASTERS-1:0]            r_valid_o,
  output logic [ID_WIDTH-1:0]               r_id_o
`ifdef TCDM_ARB_PERF_CNT_EN
  ,
  input  logic                              cnt_clr_i,
  output logic [NUM_MASTERS*16-1:0]         conflict_cnt_o
`endif
);

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [ID_WIDTH-1:0] id);
    logic [NUM_MASTERS-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [ID_WIDTH-1:0] win_id;
  logic                win_found;
  int                  scan_idx;

  logic                s1_vld_q;
  logic [ID_WIDTH-1:0] s1_id_q;
  logic                s2_vld_q;
  logic [ID_WIDTH-1:0] s2_id_q;

  // Stage 0: combinational round-robin scan starting at the pointer; the
  // first requesting master wins and its request fields drive the bank.
  always_comb begin
    gnt_o       = '0;
    win_found   = 1'b0;
    win_id      = '0;
    scan_idx    = 0;
    mem_add_o   = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
      if (!win_found && req_i[scan_idx]) begin
        win_found         = 1'b1;
        win_id            = ID_WIDTH'(scan_idx);
        gnt_o[scan_idx]   = 1'b1;
        mem_add_o         = add_i[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wen_o         = wen_i[scan_idx];
        mem_wdata_o       = wdata_i[scan_idx*DATA_WIDTH +: DATA_WIDTH];
        mem_be_o          = be_i[scan_idx*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  assign mem_req_o = |req_i;

  // The pointer moves just past the winner so the winner has lowest priority
  // next cycle; explicit wrap keeps non-power-of-two master counts correct.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= '0;
    end else if (win_found) begin
      rr_ptr_q <= (win_id == ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : win_id + 1'b1;
    end
  end

  // Stage 1: SRAM access cycle. Only reads are tracked; writes return nothing.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_vld_q <= 1'b0;
      s1_id_q  <= '0;
    end else begin
      s1_vld_q <= win_found & mem_wen_o;
      s1_id_q  <= win_id;
    end
  end

  assign pipe_rvalid_o = s1_vld_q;

  // Stage 2: response pipe stage, aligned with pipe_valid_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_vld_q <= 1'b0;
      s2_id_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_id_q  <= s1_id_q;
    end
  end

  assign r_id_o = s2_id_q;

  // The strobe follows the pipe's valid even if it disagrees with our own
  // tracking; a disagreement is a protocol error caught by the check below.
  assign r_valid_o = pipe_valid_i ? onehot(s2_id_q) : '0;

`ifdef TCDM_ARB_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q [NUM_MASTERS];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NUM_MASTERS; k++) cnt_q[k] <= '0;
    end else if (cnt_clr_i) begin
      for (int k = 0; k < NUM_MASTERS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (req_i[k] && !gnt_o[k]) cnt_q[k] <= sat_inc(cnt_q[k]);
      end
    end
  end

  always_comb begin
    conflict_cnt_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) conflict_cnt_o[k*16 +: 16] = cnt_q[k];
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rstn_i) begin
      assert (pipe_valid_i == s2_vld_q)
        else $error("tcdm_bank_arbiter: response pipe valid disagrees with read tracking");
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
module tb_tcdm_bank_arbiter;
  localparam int NM = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NM-1:0]     req_i;
  logic [NM*AW-1:0]  add_i;
  logic [NM-1:0]     wen_i;
  logic [NM*DW-1:0]  wdata_i;
  logic [NM*BW-1:0]  be_i;
  logic [NM-1:0]     gnt_o;
  logic              mem_req_o;
  logic [AW-1:0]     mem_add_o;
  logic              mem_wen_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [BW-1:0]     mem_be_o;
  logic              pipe_rvalid_o;
  logic              pipe_valid_i;
  logic [NM-1:0]     r_valid_o;
  logic [IW-1:0]     r_id_o;
`ifdef TCDM_ARB_PERF_CNT_EN
  logic              cnt_clr;
  logic [NM*16-1:0]  conflict_cnt_o;
`endif

  tcdm_bank_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .mem_req_o(mem_req_o), .mem_add_o(mem_add_o),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .pipe_rvalid_o(pipe_rvalid_o), .pipe_valid_i(pipe_valid_i),
    .r_valid_o(r_valid_o), .r_id_o(r_id_o)
`ifdef TCDM_ARB_PERF_CNT_EN
    , .cnt_clr_i(cnt_clr), .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Response pipe model: one register stage after pipe_rvalid_o.
  logic pv_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pv_q <= 1'b0;
    else       pv_q <= pipe_rvalid_o;
  end
  assign pipe_valid_i = pv_q;

  // Per-master stimulus
  logic          m_req   [NM];
  logic [AW-1:0] m_add   [NM];
  logic          m_wen   [NM];
  logic [DW-1:0] m_wdata [NM];
  logic [BW-1:0] m_be    [NM];

  always_comb begin
    req_i = '0; add_i = '0; wen_i = '0; wdata_i = '0; be_i = '0;
    for (int k = 0; k < NM; k++) begin
      req_i[k]             = m_req[k];
      add_i[k*AW +: AW]    = m_add[k];
      wen_i[k]             = m_wen[k];
      wdata_i[k*DW +: DW]  = m_wdata[k];
      be_i[k*BW +: BW]     = m_be[k];
    end
  end

  typedef struct { int due; int id; } rsp_t;
  rsp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mptr = 0;
  bit ms1 = 1'b0;
  logic [NM-1:0] obs_gnt;
  logic [NM-1:0] obs_rvalid;
  logic [IW-1:0] obs_rid;
  logic [AW-1:0] obs_add;
  logic          obs_wen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_all(input logic req, input logic wen);
    for (int k = 0; k < NM; k++) begin
      m_req[k]   = req;
      m_wen[k]   = wen;
      m_add[k]   = AW'(12'h100 + k);
      m_wdata[k] = DW'(32'hA5A50000 + k);
      m_be[k]    = BW'(4'hF);
    end
  endtask

  // One clock cycle: compare DUT against the model at the negedge, then advance.
  task automatic step();
    bit            ef;
    int            ew;
    logic [NM-1:0] eg;
    logic [NM-1:0] erv;
    rsp_t          e;
    @(negedge clk);
    ef = 1'b0; ew = 0;
    for (int i = 0; i < NM; i++) begin
      int j;
      j = (mptr + i) % NM;
      if (!ef && m_req[j]) begin ef = 1'b1; ew = j; end
    end
    eg = '0;
    if (ef) eg[ew] = 1'b1;
    chk("gnt", gnt_o, eg);
    chk("mem_req", mem_req_o, ef);
    if (ef) begin
      chk("mem_add", mem_add_o, m_add[ew]);
      chk("mem_wen", mem_wen_o, m_wen[ew]);
      chk("mem_wdata", mem_wdata_o, m_wdata[ew]);
      chk("mem_be", mem_be_o, m_be[ew]);
    end else begin
      chk("mem_add_idle", mem_add_o, 0);
      chk("mem_wdata_idle", mem_wdata_o, 0);
    end
    chk("pipe_rvalid", pipe_rvalid_o, ms1);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      erv = '0;
      erv[e.id] = 1'b1;
      chk("r_valid", r_valid_o, erv);
      chk("r_id", r_id_o, e.id);
    end else begin
      chk("r_valid_idle", r_valid_o, 0);
    end
    obs_gnt = gnt_o; obs_rvalid = r_valid_o; obs_rid = r_id_o;
    obs_add = mem_add_o; obs_wen = mem_wen_o;
    if (ef && m_wen[ew]) sb.push_back('{due: cyc + 2, id: ew});
    ms1 = ef && m_wen[ew];
    if (ef) mptr = (ew + 1) % NM;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset(input int n);
    set_all(1'b0, 1'b1);
    rstn = 1'b0;
    sb.delete();
    ms1  = 1'b0;
    mptr = 0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_ptr", dut.rr_ptr_q, 0);
    chk("rst_pipe_rvalid", pipe_rvalid_o, 0);
    chk("rst_r_valid", r_valid_o, 0);
    chk("rst_r_id", r_id_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef TCDM_ARB_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    // Reset then idle
    apply_reset(3);
    repeat (10) step();
    chk("idle_ptr", dut.rr_ptr_q, 0);
    chk("idle_gnt", obs_gnt, 0);

    // All masters read continuously from reset
    apply_reset(2);
    set_all(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_seq", obs_gnt, 4'b0001 << (i % 4));
      if (i >= 2) chk("rr_rvalid_seq", obs_rvalid, 4'b0001 << ((i - 2) % 4));
    end
    set_all(1'b0, 1'b1);
    repeat (3) step();

    // Only master 3 reads address 0x05A
    m_req[3] = 1'b1; m_add[3] = 12'h05A; m_wen[3] = 1'b1;
    step();
    chk("m3_gnt", obs_gnt, 4'b1000);
    chk("m3_add", obs_add, 12'h05A);
    chk("m3_wen", obs_wen, 1'b1);
    m_req[3] = 1'b0;
    chk("m3_pipe_rvalid", pipe_rvalid_o, 1'b1);
    step();
    step();
    chk("m3_rvalid", obs_rvalid, 4'b1000);
    chk("m3_rid", obs_rid, 3);
    chk("m3_ptr_wrap", dut.rr_ptr_q, 0);

    // Master 0 writes while master 1 reads, pointer at 0
    m_req[0] = 1'b1; m_wen[0] = 1'b0; m_wdata[0] = 32'hDEADBEEF; m_be[0] = 4'hF;
    m_req[1] = 1'b1; m_wen[1] = 1'b1; m_add[1] = 12'h3C1;
    step();
    chk("wr_gnt_first", obs_gnt, 4'b0001);
    m_req[0] = 1'b0;
    step();
    chk("rd_gnt_second", obs_gnt, 4'b0010);
    chk("wr_no_rvalid", obs_rvalid, 0);
    m_req[1] = 1'b0;
    step();
    chk("wr_no_rvalid2", obs_rvalid, 0);
    step();
    chk("rd_rvalid", obs_rvalid, 4'b0010);
    repeat (2) step();

    // Single requester granted every cycle whatever the pointer
    m_req[2] = 1'b1; m_wen[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_gnt", obs_gnt, 4'b0100);
    end
    m_req[2] = 1'b0;
    repeat (3) step();

    // Reset one cycle after a granted read drops the in-flight read
    m_req[1] = 1'b1; m_wen[1] = 1'b1;
    step();
    chk("pre_rst_gnt", obs_gnt, 4'b0010);
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rvalid", obs_rvalid, 0);
    end
    set_all(1'b1, 1'b1);
    step();
    chk("post_rst_first_gnt", obs_gnt, 4'b0001);
    set_all(1'b0, 1'b1);
    repeat (3) step();

    // Mixed random traffic checked by the scoreboard
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NM; k++) begin
        m_req[k]   = 1'($urandom_range(0, 1));
        m_wen[k]   = 1'($urandom_range(0, 1));
        m_add[k]   = AW'($urandom);
        m_wdata[k] = DW'($urandom);
        m_be[k]    = BW'($urandom);
      end
      step();
    end
    set_all(1'b0, 1'b1);
    repeat (3) step();

`ifdef TCDM_ARB_PERF_CNT_EN
    // Conflict counters: masters 0 and 1 from pointer 0 for 8 cycles
    apply_reset(2);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    m_req[0] = 1'b1; m_req[1] = 1'b1;
    repeat (8) step();
    chk("cnt_m0", conflict_cnt_o[15:0], 16'd4);
    chk("cnt_m1", conflict_cnt_o[31:16], 16'd4);
    chk("cnt_m2", conflict_cnt_o[47:32], 16'd0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt_clr_m0", conflict_cnt_o[15:0], 16'd0);
    chk("cnt_clr_m1", conflict_cnt_o[31:16], 16'd0);
    set_all(1'b0, 1'b1);
    repeat (3) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Round-robin arbiter that shares one single-port TCDM SRAM bank between NUM_MASTERS requesters.
- Issues at most one access per cycle to the bank.
- Tracks the owner of each read through the SRAM cycle and the response pipe stage.
- Steers the resulting read-valid back to the correct master as a one-hot strobe.
- Sits between the master-side crossbar ports and the bank/response-pipe pair.

Parameters:
- NUM_MASTERS, 4, number of requesters (>=2).
- ADDR_WIDTH, 12, bank word address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- ID_WIDTH, $clog2(NUM_MASTERS), master index width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_i  in  NUM_MASTERS  per-master request
- add_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master k at slice k
- wen_i  in  NUM_MASTERS  per-master write-enable, active-low: 1 = read, 0 = write
- wdata_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- be_i  in  NUM_MASTERS*BE_WIDTH  per-master byte enables
- gnt_o  out  NUM_MASTERS  one-hot grant, combinational, same cycle as req
- mem_req_o  out  1  bank access strobe
- mem_add_o  out  ADDR_WIDTH  bank address
- mem_wen_o  out  1  bank write-enable, active-low
- mem_wdata_o  out  DATA_WIDTH  bank write data
- mem_be_o  out  BE_WIDTH  bank byte enables
- pipe_rvalid_o  out  1  read-valid into the response pipe, 1 cycle after a granted read
- pipe_valid_i  in  1  valid returned by the response pipe
- r_valid_o  out  NUM_MASTERS  one-hot read-response strobe per master
- r_id_o  out  ID_WIDTH  index of the master owning the current response

Behaviour:
- Interface: one clock, clk_i; reset rstn_i is asynchronous and active-low. All flops reset on negedge rstn_i.
- Reset values:
  - rr_ptr_q = 0.
  - Stage-1 and stage-2 read-tracking valid bits = 0; stage IDs = 0.
  - pipe_rvalid_o = 0, r_valid_o = 0, r_id_o = 0.
  - gnt_o and mem_req_o are 0 whenever req_i = 0.
- Arbitration (combinational):
  - Winner = first k with req_i[k] = 1, scanning rr_ptr_q, rr_ptr_q+1, ... modulo NUM_MASTERS.
  - gnt_o[winner] = 1; all other grants 0.
  - mem_req_o = |req_i.
  - mem_add_o, mem_wen_o, mem_wdata_o and mem_be_o are muxed from the winner.
  - With no request, the mem_* data outputs are driven 0.
- Pointer update: on a cycle with a grant, rr_ptr_q <= (winner+1) mod NUM_MASTERS, with explicit wrap at NUM_MASTERS-1. With no grant, the pointer holds.
- Read tracking, stage 1 (SRAM latency):
  - s1_vld_q <= grant & wen of winner.
  - s1_id_q <= winner.
  - pipe_rvalid_o = s1_vld_q, i.e. cycle T+1 for a read granted in cycle T.
- Read tracking, stage 2 (response pipe):
  - s2_vld_q <= s1_vld_q.
  - s2_id_q <= s1_id_q.
  - r_id_o = s2_id_q.
  - r_valid_o = pipe_valid_i ? onehot(s2_id_q) : 0, i.e. cycle T+2.
- Writes are granted and issued but produce no response and no tracking entry.
- Back-to-back reads from different masters issue every cycle. Responses stay in order, one per cycle, with no bubbles.
- Simultaneous read and write requests: only the winner is issued. Losers hold req_i; they see gnt_o = 0 and retry in the next cycle.
- Single requester: granted every cycle regardless of the pointer.
- Reset mid-operation: all in-flight tracking is dropped; no r_valid_o pulses after reset release until new reads are granted.
- Error check (simulation only):
  - assert pipe_valid_i == s2_vld_q every cycle.
  - A mismatch is a protocol error: r_valid_o still follows pipe_valid_i, and the error is flagged by the assertion only.

Optional Feature:
- Macro: TCDM_ARB_PERF_CNT_EN.
- When defined, adds:
  - Output conflict_cnt_o, NUM_MASTERS*16 bits. One saturating 16-bit counter per master increments on each cycle where req_i[k] = 1 and gnt_o[k] = 0. Counters hold at 16'hFFFF and reset to 0.
  - Input cnt_clr_i. It synchronously clears all counters and takes precedence over increments in the same cycle.
- When undefined: neither port exists and no counter logic is present.

Test Plan:
- Reset then idle, req_i = 0 for 10 cycles -> gnt_o = 0, mem_req_o = 0, r_valid_o = 0, rr_ptr_q = 0.
- All 4 masters read continuously from reset -> grants cycle 0,1,2,3,0; r_valid_o = 0001,0010,0100,1000,0001, each 2 cycles after its grant.
- Only master 3 reads add 0x05A in cycle T, then the pointer check:
  - gnt_o = 1000 at T.
  - mem_add_o = 0x05A, mem_wen_o = 1 at T.
  - pipe_rvalid_o = 1 at T+1.
  - r_valid_o = 1000, r_id_o = 3 at T+2.
  - rr_ptr_q wraps to 0.
- Master 0 writes 0xDEADBEEF with be 0xF while master 1 reads, pointer = 0 ->
  - Master 0 granted first, write issued with no r_valid_o.
  - Master 1 granted next cycle; its read response arrives 2 cycles later.
- Reset asserted one cycle after a granted read -> no r_valid_o after release; first post-reset grant goes to master 0.
- With TCDM_ARB_PERF_CNT_EN, masters 0 and 1 request for 8 cycles from pointer 0 -> each conflict counter = 4; cnt_clr_i pulse -> both counters 0.
